// File: rtl/sram_2rw_ctrl.sv
// sram_2rw_ctrl: two-port read/write SRAM controller with power-up clear, lane write masks and write-through bypass
module sram_2rw_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6,
  parameter int MASK_GRAN = 8,
  parameter int READ_LAT = 1,
  localparam int NLANE = WIDTH / MASK_GRAN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p1_en,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [NLANE-1:0]  p1_wmask,
  input  logic [WIDTH-1:0]  p1_wdata,
  output logic [WIDTH-1:0]  p1_rdata,
  output logic              p1_rvalid,
  input  logic              p2_en,
  input  logic              p2_we,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [NLANE-1:0]  p2_wmask,
  input  logic [WIDTH-1:0]  p2_wdata,
  output logic [WIDTH-1:0]  p2_rdata,
  output logic              p2_rvalid,
  output logic              init_done,
  output logic              collision
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [1:0] acc, we, stage_v, rvalid, last_v;
  logic [ADDR_W-1:0] addr [2];
  logic [NLANE-1:0] wmask [2];
  logic [WIDTH-1:0] wdata [2], word [2], stage_d [2], rdata [2], last_d [2];
  assign init_done = state == READY;
  assign acc = {p2_en, p1_en} & {2{init_done}};
  assign we = {p2_we, p1_we};
  assign addr[0] = p1_addr;
  assign addr[1] = p2_addr;
  assign wmask[0] = p1_wmask;
  assign wmask[1] = p2_wmask;
  assign wdata[0] = p1_wdata;
  assign wdata[1] = p2_wdata;
  assign p1_rdata = rdata[0];
  assign p2_rdata = rdata[1];
  assign p1_rvalid = rvalid[0];
  assign p2_rvalid = rvalid[1];
  // Port 2 lanes are applied first so port 1 wins any lane both ports enable
  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] base, input logic [ADDR_W-1:0] a);
    merge = base;
    for (int p = 1; p >= 0; p--)
      for (int k = 0; k < NLANE; k++)
        if (acc[p] && we[p] && addr[p] == a && wmask[p][k])
          merge[k*MASK_GRAN +: MASK_GRAN] = wdata[p][k*MASK_GRAN +: MASK_GRAN];
  endfunction
  always_comb state_nx = (state == CLEAR && ptr == ADDR_W'(DEPTH - 1)) ? READY : state;
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      word[p] = int'(addr[p]) < DEPTH ? merge(mem[addr[p]], addr[p]) : '0;
      last_d[p] = READ_LAT == 2 ? stage_d[p] : word[p];
    end
    last_v = READ_LAT == 2 ? stage_v : acc & ~we;
  end
  always_ff @(posedge clock)
    for (int i = 0; i < DEPTH; i++)
      mem[i] <= (state == CLEAR && ptr == ADDR_W'(i)) ? '0 : merge(mem[i], ADDR_W'(i));
  always_ff @(posedge clock)
    if (reset) begin
      state <= CLEAR;
      ptr <= '0;
      stage_v <= '0;
      rvalid <= '0;
      collision <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        stage_d[p] <= '0;
        rdata[p] <= '0;
      end
    end else begin
      state <= state_nx;
      ptr <= state == CLEAR ? ptr + 1'b1 : ptr;
      stage_v <= acc & ~we;
      rvalid <= last_v;
      collision <= &acc && addr[0] == addr[1] && |we;
      for (int p = 0; p < 2; p++) begin
        stage_d[p] <= word[p];
        rdata[p] <= last_v[p] ? last_d[p] : rdata[p];
      end
    end
endmodule

// File: tb/tb_sram_2rw_ctrl.sv
// tb_sram_2rw_ctrl: random and directed checks of both read latencies against a behavioural memory model
module tb_sram_2rw_ctrl;
  logic clock = 1'b0, reset = 1'b1;
  logic p1_en = 0, p1_we = 0, p2_en = 0, p2_we = 0;
  logic [5:0] p1_addr = 0, p2_addr = 0;
  logic [1:0] p1_wmask = 0, p2_wmask = 0;
  logic [15:0] p1_wdata = 0, p2_wdata = 0;
  logic [15:0] a1_rdata, a2_rdata, b1_rdata, b2_rdata;
  logic a1_rvalid, a2_rvalid, b1_rvalid, b2_rvalid, a_init, b_init, a_col, b_col;
  int n_tests = 0, n_fail = 0;
  logic [15:0] mdl [64];
  bit ready;
  int clr;
  bit e_v1 [2], e_v2 [2], pend_v [2], e_col;
  logic [15:0] e_rd1 [2], e_rd2 [2], pend_d [2];

  always #5 clock = ~clock;

  sram_2rw_ctrl #(.READ_LAT(1)) dut_a (
    .clock(clock), .reset(reset),
    .p1_en(p1_en), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wmask(p1_wmask), .p1_wdata(p1_wdata),
    .p1_rdata(a1_rdata), .p1_rvalid(a1_rvalid),
    .p2_en(p2_en), .p2_we(p2_we), .p2_addr(p2_addr), .p2_wmask(p2_wmask), .p2_wdata(p2_wdata),
    .p2_rdata(a2_rdata), .p2_rvalid(a2_rvalid),
    .init_done(a_init), .collision(a_col));

  sram_2rw_ctrl #(.READ_LAT(2)) dut_b (
    .clock(clock), .reset(reset),
    .p1_en(p1_en), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wmask(p1_wmask), .p1_wdata(p1_wdata),
    .p1_rdata(b1_rdata), .p1_rvalid(b1_rvalid),
    .p2_en(p2_en), .p2_we(p2_we), .p2_addr(p2_addr), .p2_wmask(p2_wmask), .p2_wdata(p2_wdata),
    .p2_rdata(b2_rdata), .p2_rvalid(b2_rvalid),
    .init_done(b_init), .collision(b_col));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input bit e, input bit w, input int a, input int m, input int d);
    if (p == 1) begin
      p1_en = e; p1_we = w; p1_addr = 6'(a); p1_wmask = 2'(m); p1_wdata = 16'(d);
    end else begin
      p2_en = e; p2_we = w; p2_addr = 6'(a); p2_wmask = 2'(m); p2_wdata = 16'(d);
    end
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0, 0);
  endtask

  // Model one clock edge from the currently driven inputs, then compare both DUTs
  task automatic step();
    bit en [2], w [2], acc [2];
    logic [5:0] a [2];
    logic [1:0] m [2];
    logic [15:0] d [2], rd [2];
    en = '{p1_en, p2_en}; w = '{p1_we, p2_we}; a = '{p1_addr, p2_addr};
    m = '{p1_wmask, p2_wmask}; d = '{p1_wdata, p2_wdata};
    if (reset) begin
      ready = 0; clr = 0; e_col = 0;
      foreach (mdl[i]) mdl[i] = '0;
      for (int p = 0; p < 2; p++) begin
        e_v1[p] = 0; e_v2[p] = 0; pend_v[p] = 0; e_rd1[p] = '0; e_rd2[p] = '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) acc[p] = en[p] && ready;
      for (int p = 0; p < 2; p++)
        if (acc[p] && w[p])
          for (int l = 0; l < 2; l++)
            if (m[p][l] && !(p == 1 && acc[0] && w[0] && a[0] == a[1] && m[0][l]))
              mdl[a[p]][l*8 +: 8] = d[p][l*8 +: 8];
      for (int p = 0; p < 2; p++) begin
        rd[p] = mdl[a[p]];
        e_v1[p] = acc[p] && !w[p];
        if (e_v1[p]) e_rd1[p] = rd[p];
        e_v2[p] = pend_v[p];
        if (e_v2[p]) e_rd2[p] = pend_d[p];
        pend_v[p] = e_v1[p];
        pend_d[p] = rd[p];
      end
      e_col = acc[0] && acc[1] && a[0] == a[1] && (w[0] || w[1]);
      if (!ready) begin
        clr++;
        if (clr == 64) ready = 1;
      end
    end
    @(posedge clock);
    #1;
    chk("a_init_done", a_init, ready);
    chk("b_init_done", b_init, ready);
    chk("a_collision", a_col, e_col);
    chk("b_collision", b_col, e_col);
    chk("a_p1_rvalid", a1_rvalid, e_v1[0]);
    chk("a_p2_rvalid", a2_rvalid, e_v1[1]);
    chk("b_p1_rvalid", b1_rvalid, e_v2[0]);
    chk("b_p2_rvalid", b2_rvalid, e_v2[1]);
    chk("a_p1_rdata", a1_rdata, e_rd1[0]);
    chk("a_p2_rdata", a2_rdata, e_rd1[1]);
    chk("b_p1_rdata", b1_rdata, e_rd2[0]);
    chk("b_p2_rdata", b2_rdata, e_rd2[1]);
  endtask

  task automatic rand_port(input int p);
    drive(p, 1'($urandom), 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 3), int'($urandom));
  endtask

  initial begin
    repeat (3) step();
    // reset mid-clear restarts the sweep
    reset = 0;
    repeat (20) step();
    reset = 1;
    step();
    reset = 0;
    drive(1, 1, 0, 7, 0, 0);
    repeat (63) step();
    chk("init_low_at_63", a_init, 0);
    step();
    chk("init_high_at_64", a_init, 1);
    chk("no_rvalid_during_clear", a1_rvalid, 0);
    for (int i = 0; i < 64; i++) begin
      drive(1, 1, 0, i, 0, 0);
      drive(2, 1, 0, 63 - i, 0, 0);
      step();
      chk("clear_zero", a1_rdata, 16'h0000);
    end
    drive(1, 1, 1, 5, 3, 16'hABCD); drive(2, 0, 0, 0, 0, 0);
    step();
    drive(1, 1, 1, 5, 1, 16'h1234);
    step();
    chk("wr_no_rvalid", a1_rvalid, 0);
    idle(); drive(2, 1, 0, 5, 0, 0);
    step();
    chk("mask_merge", a2_rdata, 16'hAB34);
    chk("mask_merge_valid", a2_rvalid, 1);
    idle();
    step();
    chk("rvalid_single_pulse", a2_rvalid, 0);
    chk("rdata_hold", a2_rdata, 16'hAB34);
    drive(1, 1, 1, 9, 3, 16'h5A5A); drive(2, 1, 0, 9, 0, 0);
    step();
    chk("bypass", a2_rdata, 16'h5A5A);
    chk("bypass_collision", a_col, 1);
    idle();
    step();
    chk("collision_pulse_end", a_col, 0);
    drive(1, 1, 1, 3, 1, 16'h1111); drive(2, 1, 1, 3, 3, 16'h2222);
    step();
    chk("ww_collision", a_col, 1);
    idle(); drive(1, 1, 0, 3, 0, 0);
    step();
    chk("ww_merge", a1_rdata, 16'h2211);
    chk("ww_collision_once", a_col, 0);
    drive(1, 1, 0, 9, 0, 0); drive(2, 1, 0, 9, 0, 0);
    step();
    chk("rr_no_collision", a_col, 0);
    drive(1, 1, 1, 1, 3, 1); drive(2, 1, 1, 2, 3, 2);
    step();
    drive(1, 1, 1, 3, 3, 3); drive(2, 0, 0, 0, 0, 0);
    step();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 1, 0, i, 0, 0);
      step();
      chk("lat2_valid", b1_rvalid, i > 1);
      if (i > 1) chk("lat2_data", b1_rdata, i - 1);
    end
    idle();
    step();
    chk("lat2_valid_last", b1_rvalid, 1);
    chk("lat2_data_last", b1_rdata, 3);
    step();
    chk("lat2_valid_end", b1_rvalid, 0);
    repeat (500) begin
      rand_port(1);
      rand_port(2);
      step();
    end
    drive(1, 1, 1, 40, 3, 16'hBEEF); drive(2, 0, 0, 0, 0, 0);
    step();
    drive(1, 1, 0, 40, 0, 0);
    repeat (10) step();
    chk("pre_reset_data", a1_rdata, 16'hBEEF);
    reset = 1;
    step();
    chk("reset_rdata", a1_rdata, 0);
    chk("reset_rvalid", a1_rvalid, 0);
    chk("reset_init", a_init, 0);
    reset = 0;
    repeat (64) step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, i == 0 ? 40 : i == 1 ? 5 : 9, 0, 0);
      drive(2, 1, 0, 3, 0, 0);
      step();
      chk("post_reset_p1_zero", a1_rdata, 0);
      chk("post_reset_p2_zero", a2_rdata, 0);
    end
    idle();
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_2rw_ctrl.md
SRAM_2RW_CTRL -- requirements
Module: sram_2rw_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits; SHALL be a multiple of MASK_GRAN.
REQ-002 Parameter DEPTH, default 64: number of words; SHALL be 2 or more.
REQ-003 Parameter ADDR_W, default 6: address width; SHALL equal clog2(DEPTH).
REQ-004 Parameter MASK_GRAN, default 8: bits per write-mask lane; NLANE = WIDTH/MASK_GRAN.
REQ-005 Parameter READ_LAT, default 1: read latency in cycles; legal values are 1 and 2.
REQ-006 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 pN_en  in  1  port N request (N = 1, 2).
REQ-009 pN_we  in  1  1 = write, 0 = read.
REQ-010 pN_addr  in  ADDR_W  word address.
REQ-011 pN_wmask  in  NLANE  per-lane write enable.
REQ-012 pN_wdata  in  WIDTH  write data.
REQ-013 pN_rdata  out  WIDTH  read data.
REQ-014 pN_rvalid  out  1  single-cycle pulse qualifying pN_rdata.
REQ-015 init_done  out  1  high once memory clear completes; accepts requests.
REQ-016 collision  out  1  single-cycle pulse: same-address conflict detected.

Function
REQ-017 FSM SHALL have two states, CLEAR and READY; reset SHALL force CLEAR and set the sweep pointer to 0.
REQ-018 CLEAR SHALL write 0 to address ptr each cycle, ptr++; the cycle ptr==DEPTH-1 is written SHALL transition to READY (clear takes exactly DEPTH cycles).
REQ-019 init_done SHALL be 1 only in READY; port requests in CLEAR SHALL be ignored (no write, no rvalid).
REQ-020 Accepted request: pN_en & init_done.
REQ-021 Write: lane k of mem[addr] SHALL be replaced by wdata lane k where wmask[k]=1; other lanes unchanged; wmask all-zero is a no-op write.
REQ-022 Read: pN_rvalid SHALL pulse exactly READ_LAT cycles after acceptance, with pN_rdata = word at acceptance edge.
REQ-023 pN_rdata SHALL hold its last value when no rvalid pulse is issued.
REQ-024 Writes produce no rvalid and leave pN_rdata unchanged.
REQ-025 Reads pipeline fully: one accepted read per port per cycle, results in order.
REQ-026 Port X write + port Y read, same address, same cycle: port Y SHALL return the post-write merged word (write-through bypass).
REQ-027 Both ports write the same address in the same cycle: lanes enabled in p1_wmask SHALL take p1 data; lanes enabled only in p2_wmask SHALL take p2 data.
REQ-028 Both ports read the same address: both return identical data; not a collision.
REQ-029 collision SHALL pulse one cycle after any accepted same-address pair with at least one write, including write/write with disjoint masks.
REQ-030 Address >= DEPTH (non-power-of-2 DEPTH): write dropped, read returns 0, rvalid still pulses.
REQ-031 No combinational path from any input to any output.

Reset
REQ-032 On reset: pN_rdata=0, pN_rvalid=0, collision=0, init_done=0, all in-flight reads discarded.
REQ-033 Reset asserted mid-CLEAR or mid-READY SHALL restart the clear from address 0; memory contents after reset release are all zero once init_done rises.

Verification
REQ-034 Release reset, hold p1_en=1 -> init_done rises exactly 64 cycles later; no rvalid before; read of addr 0..63 all return 0x0000.
REQ-035 p1 write addr 5 = 0xABCD mask 2'b11, then mask 2'b01 data 0x1234 -> p2 read addr 5 returns 0xAB34, rvalid 1 cycle later (READ_LAT=1).
REQ-036 Same cycle p1 write addr 9 = 0x5A5A, p2 read addr 9 (old 0x0000) -> p2_rdata=0x5A5A; collision pulses next cycle.
REQ-037 Same cycle p1 write addr 3 = 0x1111 mask 2'b01, p2 write addr 3 = 0x2222 mask 2'b11 -> mem[3]=0x2211; collision pulses once.
REQ-038 READ_LAT=2, back-to-back p1 reads addr 1,2,3 holding 0x0001..0x0003 -> rvalid high 3 consecutive cycles starting 2 cycles after first, data in order.
REQ-039 Reset asserted 10 cycles into READY after writes -> outputs zero immediately, init_done low for 64 cycles, previously written addresses read 0x0000.
